// File: rtl/imm_pkg.sv
// Shared types and the immediate decode function for the decode-stage immediate generator.
package imm_pkg;

  localparam int unsigned INSTR_W   = 25;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned IMM_MAX_W = 64;

  typedef enum logic [SEL_W-1:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_Z    = 3'd5,
    IMM_SH   = 3'd6,
    IMM_RSVD = 3'd7
  } imm_sel_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_cnt_e;

  // Only RV32 and RV64 immediate widths are supported.
  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Builds the immediate at full 64-bit width; callers truncate to their XLEN.
  // instr[k] holds instruction bit k+7, so instruction bit 31 is instr[24].
  function automatic logic [IMM_MAX_W-1:0] build_imm(input logic [INSTR_W-1:0] instr,
                                                     input imm_sel_e          sel,
                                                     input int unsigned       xlen);
    logic                 s;
    logic [IMM_MAX_W-1:0] imm;
    s   = instr[24];
    imm = '0;
    case (sel)
      IMM_I:  imm = {{52{s}}, instr[24:13]};
      IMM_S:  imm = {{52{s}}, instr[24:18], instr[4:0]};
      IMM_B:  imm = {{51{s}}, s, instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_U:  imm = {{32{s}}, instr[24:5], 12'h000};
      IMM_J:  imm = {{43{s}}, s, instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_Z:  imm = {59'd0, instr[12:8]};
      IMM_SH: imm = (xlen == 64) ? {58'd0, instr[18:13]} : {59'd0, instr[17:13]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/imm_fifo2.sv
// Generic 2-entry valid/ready FIFO; ready depends only on registered occupancy.
module imm_fifo2
  import imm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  fifo_cnt_e        state, state_n;
  logic             wr_ptr, wr_ptr_n;
  logic             rd_ptr, rd_ptr_n;
  logic [WIDTH-1:0] mem [2];
  logic             push, pop;

  // Occupancy, pointers and storage; reset also wipes the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FIFO_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      if (push) mem[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    state_n   = state;

    in_ready  = !rst && (state != FIFO_FULL);
    out_valid = (state != FIFO_EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    case (state)
      FIFO_EMPTY: if (push) state_n = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_n = FIFO_FULL;
        else if (!push && pop) state_n = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop) state_n = FIFO_ONE;
      default:    state_n = FIFO_EMPTY;
    endcase

    wr_ptr_n = wr_ptr ^ push;
    rd_ptr_n = rd_ptr ^ pop;
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes at the push and buffers {imm, err, tag} in a 2-deep FIFO.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_err,
  output logic [TAG_W-1:0]   out_tag
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  imm_sel_e sel;
  entry_t   push_entry;
  entry_t   head_entry;

  assign sel = imm_sel_e'(in_sel);

  // Entries are stored fully extended so the output side is pure storage.
  always_comb begin
    push_entry     = '0;
    push_entry.imm = XLEN'(build_imm(in_instr, sel, XLEN));
    push_entry.err = (sel == IMM_RSVD);
    push_entry.tag = in_tag;
  end

  imm_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry)
  );

  assign out_imm = head_entry.imm;
  assign out_err = head_entry.err;
  assign out_tag = head_entry.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one request stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [24:0] in_instr;
  logic [2:0]  in_sel;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, in_ready64;
  logic        out_valid32, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic        out_err32, out_err64;
  logic [7:0]  out_tag32, out_tag64;

  int errors = 0;
  int checks = 0;
  int npops  = 0;
  bit bp_rand = 1'b0;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic        err;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_err(out_err32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_err(out_err64), .out_tag(out_tag64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: immediates as signed integers assembled from bit weights.
  function automatic void model(input logic [31:0] ins, input logic [2:0] sel,
                                output logic [31:0] e32, output logic [63:0] e64,
                                output logic err);
    longint v;
    v   = 0;
    err = 1'b0;
    case (sel)
      3'd0: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      3'd1: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      3'd2: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end
      3'd4: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      3'd5: v = longint'(ins[19:15]);
      3'd6: v = 0;
      default: err = 1'b1;
    endcase
    e64 = 64'(v);
    e32 = e64[31:0];
    if (sel == 3'd6) begin
      e32 = 32'(ins[24:20]);
      e64 = 64'(ins[25:20]);
    end
  endfunction

  // Presents one request and holds it until accepted; returns cycles spent waiting.
  task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [7:0] tag,
                      input bit ovr, input logic [31:0] x32, input logic [63:0] x64,
                      output int waits);
    exp_t e;
    in_valid = 1'b1;
    in_instr = ins[31:7];
    in_sel   = sel;
    in_tag   = tag;
    model(ins, sel, e.imm32, e.imm64, e.err);
    if (ovr) begin
      e.imm32 = x32;
      e.imm64 = x64;
    end
    e.tag = tag;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready32) break;
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
        break;
      end
    end
    if (waits <= 200) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand(output int waits, input bit legal_only);
    logic [2:0] sel;
    sel = legal_only ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
    send($urandom, sel, 8'($urandom), 1'b0, '0, '0, waits);
  endtask

  // Monitor: pops the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid32 && out_ready) begin
      npops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %h expected no output", out_tag32);
      end else begin
        e = sb.pop_front();
        chk("valid64", 64'(out_valid64), 64'd1);
        chk("imm32", 64'(out_imm32), 64'(e.imm32));
        chk("imm64", out_imm64, e.imm64);
        chk("err32", 64'(out_err32), 64'(e.err));
        chk("err64", 64'(out_err64), 64'(e.err));
        chk("tag32", 64'(out_tag32), 64'(e.tag));
        chk("tag64", 64'(out_tag64), 64'(e.tag));
      end
    end
  end

  always @(posedge clk) begin
    if (bp_rand) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int p0;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_sel = '0; in_tag = '0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready32), 64'd0);
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_out_imm64", out_imm64, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk); #1;

    // Directed decode vectors with hand-derived results
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 8'h10, 1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, w);
    send(32'hFE000EE3, 3'd2, 8'h11, 1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, w);
    send(32'h0010006F, 3'd4, 8'h12, 1, 32'h00000800, 64'h0000000000000800, w);
    send(32'h123450B7, 3'd3, 8'h13, 1, 32'h12345000, 64'h0000000012345000, w);
    send(32'h000F8073, 3'd5, 8'h14, 1, 32'h0000001F, 64'h000000000000001F, w);
    send(32'h80000037, 3'd3, 8'h15, 1, 32'h80000000, 64'hFFFFFFFF80000000, w);
    send(32'h03F00013, 3'd6, 8'h16, 1, 32'h0000001F, 64'h000000000000003F, w);
    send(32'hFE000023, 3'd1, 8'h17, 1, 32'hFFFFFFE0, 64'hFFFFFFFFFFFFFFE0, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Back-pressure: fill, hold, then drain
    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 8'd1, 0, '0, '0, w);
    send(32'h00200093, 3'd0, 8'd2, 0, '0, '0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready32), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid32), 64'd1);
      chk("hold_tag", 64'(out_tag32), 64'd1);
      chk("hold_imm", 64'(out_imm32), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00300093, 3'd0, 8'd3, 0, '0, '0, w);
    chk("third_push_wait", 64'(w), 64'd1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Push and pop together at occupancy one
    send_rand(w, 1'b1);
    p0 = npops;
    for (int i = 0; i < 20; i++) begin
      send_rand(w, 1'b1);
      chk("pp_no_stall", 64'(w), 64'd0);
    end
    chk("pp_pop_count", 64'(npops - p0), 64'd20);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reserved select, then a legal request
    send($urandom, 3'd7, 8'hA5, 0, '0, '0, w);
    send(32'h00500093, 3'd0, 8'h5A, 0, '0, '0, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset with the buffer full
    out_ready = 1'b0;
    send(32'h00700093, 3'd0, 8'h21, 0, '0, '0, w);
    send(32'h00800093, 3'd0, 8'h22, 0, '0, '0, w);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid32), 64'd0);
    chk("flush_imm32", 64'(out_imm32), 64'd0);
    chk("flush_imm64", out_imm64, 64'd0);
    chk("flush_err", 64'(out_err32), 64'd0);
    chk("flush_tag", 64'(out_tag64), 64'd0);
    chk("flush_in_ready", 64'(in_ready64), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00900093, 3'd0, 8'h33, 0, '0, '0, w);
    in_valid = 1'b0;
    chk("post_flush_latency_valid", 64'(out_valid32), 64'd1);
    chk("post_flush_latency_tag", 64'(out_tag32), 64'h33);
    repeat (3) @(posedge clk); #1;

    // Randomized traffic with random back-pressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) send_rand(w, 1'b0);
    in_valid = 1'b0;
    bp_rand = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
